stack_access_ctrl: RTL and testbench
====================================

// Module: stack_access_ctrl
// PURPOSE
//  Sequencer between the stack-machine decode stage and a single-port synchronous stack RAM.
//  Serialises push / pop-one / pop-two requests into RAM cycles and owns the stack pointer.
//  Returns popped operands (top, next-top) and flags overflow/underflow instead of corrupting the stack.
//  Operation encoding matches the stack-update modes: 01 push, 11 pop1, 10 pop2, 00 nop.
// PARAMETERS
//  REG_BITS    32  data word width (16 or 32)
//  DEPTH_BITS  8   log2 of stack depth; the stack holds 2**DEPTH_BITS entries
// PORTS
//  clk        in   1             single clock, all state updates on rising edge
//  reset      in   1             asynchronous, active-high; clears all state
//  cmd_valid  in   1             request present
//  cmd_ready  out  1             controller idle; request accepted when cmd_valid && cmd_ready
//  cmd_op     in   2             01 push, 11 pop1, 10 pop2, 00 nop
//  cmd_wdata  in   REG_BITS      push data; sampled only at accept
//  rsp_valid  out  1             one-cycle completion pulse
//  rsp_err    out  1             qualified by rsp_valid: overflow or underflow, nothing done
//  rsp_read1  out  REG_BITS      popped top-of-stack
//  rsp_read2  out  REG_BITS      popped next-top (pop2 only)
//  sp         out  DEPTH_BITS+1  entry count; top lives at address sp-1
//  full       out  1             sp == 2**DEPTH_BITS
//  empty      out  1             sp == 0
//  ram_en     out  1             RAM access this cycle
//  ram_we     out  1             write strobe, qualified by ram_en
//  ram_addr   out  DEPTH_BITS    RAM address
//  ram_wdata  out  REG_BITS      RAM write data
//  ram_rdata  in   REG_BITS      RAM read data, valid one cycle after a read is issued
// BEHAVIOUR
//  Reset: state IDLE, sp=0, rsp_valid=0, rsp_err=0, rsp_read1/2=0, ram_en=0, ram_we=0.
//  Reset: ram_addr=0, ram_wdata=0, cmd_ready=1, empty=1, full=0.
//  Reset is asynchronous. An in-flight command is discarded: no rsp_valid, sp=0, and ram_en drops immediately.
//  FSM states: IDLE, WRITE, READ_TOP, READ_NEXT, CAPTURE, RESP. cmd_ready=1 only in IDLE.
//  IDLE: on accept, latch op and wdata, then check:
//    push with full, pop1 with sp<1, or pop2 with sp<2 -> RESP with err=1; no RAM access, sp unchanged.
//    nop -> RESP with err=0.
//    push -> WRITE.
//    pop1 / pop2 -> READ_TOP.
//  WRITE: ram_en=1, ram_we=1, addr=sp[DEPTH_BITS-1:0], wdata=latched; sp<=sp+1; -> RESP.
//  READ_TOP: ram_en=1, ram_we=0, addr=sp-1; pop1 -> CAPTURE, pop2 -> READ_NEXT.
//  READ_NEXT: ram_en=1, addr=sp-2; rsp_read1<=ram_rdata; -> CAPTURE.
//  CAPTURE: pop1 -> rsp_read1<=ram_rdata, rsp_read2<=0, sp<=sp-1.
//           pop2 -> rsp_read2<=ram_rdata, sp<=sp-2. Both -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle, rsp_err as decided at accept; -> IDLE.
//  Latency, accept edge to rsp_valid high: error/nop 1, push 2, pop1 3, pop2 4 cycles.
//    Next accept is possible the cycle after RESP.
//  rsp_read1/2 hold their last captured value across push, nop and error responses.
//  sp, full and empty are registered and change only in WRITE/CAPTURE, never on error.
//  sp never wraps: the full/underflow checks are the only guard and must block every wrapping op.
//  cmd_op/cmd_wdata changes while not ready are ignored. cmd_valid held high gives one accept per idle cycle.
//  ram_en=0 in IDLE and RESP. ram_we=1 only in WRITE.
// TESTING
//  1. Push 0x11, 0x22, 0x33 -> sp=3, RAM[0..2]=11,22,33, each rsp_valid 2 cycles after accept with err=0.
//  2. Then pop2 -> rsp_valid at +4, read1=0x33, read2=0x22, sp=1, err=0;
//     then pop1 -> +3, read1=0x11, read2=0, sp=0, empty=1.
//  3. sp=1, pop2 -> rsp_valid at +1, err=1, sp=1, ram_en never asserted;
//     sp=0, pop1 -> err=1.
//  4. DEPTH_BITS=2: push 4 words -> full=1, sp=4; 5th push -> err=1, sp=4, no write;
//     pop1 returns the 4th word.
//  5. Assert reset during READ_NEXT of a pop2 -> ram_en low the same cycle, sp=0, no rsp_valid,
//     cmd_ready=1 after release.
//  6. Hold cmd_valid high with alternating push/pop1 -> one accept per IDLE, no lost or duplicated command.
//     Final sp matches the command count.

Source files
------------

// File: rtl/stack_access_ctrl.sv
// Stack access sequencer: turns push / pop1 / pop2 requests into single-port RAM
// cycles, owns the stack pointer and returns popped operands with overflow/underflow flags.
module stack_access_ctrl #(
    parameter int REG_BITS   = 32,
    parameter int DEPTH_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_BITS-1:0]   cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [REG_BITS-1:0]   rsp_read1,
    output logic [REG_BITS-1:0]   rsp_read2,
    output logic [DEPTH_BITS:0]   sp,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DEPTH_BITS-1:0] ram_addr,
    output logic [REG_BITS-1:0]   ram_wdata,
    input  logic [REG_BITS-1:0]   ram_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ_TOP  = 3'd2;
    localparam logic [2:0] S_READ_NEXT = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP2 = 2'b10;
    localparam logic [1:0] OP_POP1 = 2'b11;

    localparam logic [DEPTH_BITS:0] SP_ONE = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0] SP_TWO = (DEPTH_BITS+1)'(2);
    localparam logic [DEPTH_BITS:0] SP_MAX = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [REG_BITS-1:0]   wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DEPTH_BITS:0]   sp_q, sp_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [REG_BITS-1:0]   read1_q, read1_d;
    logic [REG_BITS-1:0]   read2_q, read2_d;

    logic [DEPTH_BITS:0]   sp_m1;
    logic [DEPTH_BITS:0]   sp_m2;
    logic [DEPTH_BITS:0]   sp_inc;
    logic [DEPTH_BITS:0]   sp_pop;

    assign sp_m1  = sp_q - SP_ONE;
    assign sp_m2  = sp_q - SP_TWO;
    assign sp_inc = sp_q + SP_ONE;
    assign sp_pop = (op_q == OP_POP2) ? sp_m2 : sp_m1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        sp_d    = sp_q;
        full_d  = full_q;
        empty_d = empty_q;
        read1_d = read1_q;
        read2_d = read2_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    wdata_d = cmd_wdata;
                    err_d   = 1'b0;
                    // Any op that would wrap sp is refused here with no RAM access.
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full_q) begin
                                err_d   = 1'b1;
                                state_d = S_RESP;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                        OP_POP1: begin
                            if (empty_q) begin
                                err_d   = 1'b1;
                                state_d = S_RESP;
                            end else begin
                                state_d = S_READ_TOP;
                            end
                        end
                        OP_POP2: begin
                            if (sp_q < SP_TWO) begin
                                err_d   = 1'b1;
                                state_d = S_RESP;
                            end else begin
                                state_d = S_READ_TOP;
                            end
                        end
                        default: state_d = S_RESP;
                    endcase
                end
            end
            S_WRITE: begin
                sp_d    = sp_inc;
                full_d  = (sp_inc == SP_MAX);
                empty_d = 1'b0;
                state_d = S_RESP;
            end
            S_READ_TOP: begin
                state_d = (op_q == OP_POP2) ? S_READ_NEXT : S_CAPTURE;
            end
            S_READ_NEXT: begin
                // Top word returns while the next-top read is being issued.
                read1_d = ram_rdata;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (op_q == OP_POP2) begin
                    read2_d = ram_rdata;
                end else begin
                    read1_d = ram_rdata;
                    read2_d = '0;
                end
                sp_d    = sp_pop;
                full_d  = 1'b0;
                empty_d = (sp_pop == '0);
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            wdata_q <= '0;
            err_q   <= 1'b0;
            sp_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            read1_q <= '0;
            read2_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            read1_q <= read1_d;
            read2_q <= read2_d;
        end
    end

    // RAM strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            S_WRITE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = sp_q[DEPTH_BITS-1:0];
                ram_wdata = wdata_q;
            end
            S_READ_TOP: begin
                ram_en   = 1'b1;
                ram_addr = sp_m1[DEPTH_BITS-1:0];
            end
            S_READ_NEXT: begin
                ram_en   = 1'b1;
                ram_addr = sp_m2[DEPTH_BITS-1:0];
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_read1 = read1_q;
    assign rsp_read2 = read2_q;
    assign sp        = sp_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Self-checking bench for stack_access_ctrl: queue-based stack reference model,
// scoreboard of expected responses and an independent response monitor.
module tb_stack_access_ctrl;

    localparam int RB   = 32;
    localparam int DB   = 2;
    localparam int NENT = 4;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP2 = 2'b10;
    localparam logic [1:0] POP1 = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [RB-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [RB-1:0] rsp_read1;
    logic [RB-1:0] rsp_read2;
    logic [DB:0]   sp;
    logic          full;
    logic          empty;
    logic          ram_en;
    logic          ram_we;
    logic [DB-1:0] ram_addr;
    logic [RB-1:0] ram_wdata;
    logic [RB-1:0] ram_rdata;

    stack_access_ctrl #(.REG_BITS(RB), .DEPTH_BITS(DB)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_read1(rsp_read1), .rsp_read2(rsp_read2),
        .sp(sp), .full(full), .empty(empty),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read.
    logic [RB-1:0] mem [NENT];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] r1;
        logic [31:0] r2;
        int          sp;
        int          lat;
        int          acc;
        int          wr;
        int          acc_cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] stk[$];
    logic [31:0] last_r1 = '0;
    logic [31:0] last_r2 = '0;
    int total = 0, passed = 0;
    int n_acc = 0, n_resp = 0, n_flushed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the stack is a queue, back = top of stack.
    function automatic exp_t model_apply(input logic [1:0] op, input logic [31:0] d);
        exp_t e;
        e.err = 1'b0; e.lat = 1; e.acc = 0; e.wr = 0; e.acc_cyc = 0;
        case (op)
            PUSH: if (stk.size() == NENT) e.err = 1'b1;
                  else begin stk.push_back(d); e.lat = 2; e.acc = 1; e.wr = 1; end
            POP1: if (stk.size() < 1) e.err = 1'b1;
                  else begin last_r1 = stk.pop_back(); last_r2 = '0; e.lat = 3; e.acc = 1; end
            POP2: if (stk.size() < 2) e.err = 1'b1;
                  else begin last_r1 = stk.pop_back(); last_r2 = stk.pop_back(); e.lat = 4; e.acc = 2; end
            default: e.lat = 1;
        endcase
        e.r1 = last_r1;
        e.r2 = last_r2;
        e.sp = stk.size();
        return e;
    endfunction

    // One negedge of stimulus; scramble drives junk op/data while the DUT is busy.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] d,
                        input logic scramble, output logic acc);
        exp_t e;
        @(negedge clk);
        acc = v && cmd_ready;
        cmd_valid = v;
        if (!cmd_ready && scramble) begin
            cmd_op    = 2'($urandom);
            cmd_wdata = $urandom;
        end else begin
            cmd_op    = op;
            cmd_wdata = d;
        end
        if (acc) begin
            e = model_apply(op, d);
            e.acc_cyc = cyc + 1;
            sbq.push_back(e);
            n_acc++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, op, d, 1'b0, acc);
        if (!acc) check("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && (sbq.size() != 0 || !cmd_ready); i++)
            step(1'b0, NOP, '0, 1'b0, acc);
        check("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a command.
    exp_t mon_e;
    int   acc_cnt = 0, wr_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_cnt = 0;
                wr_cnt  = 0;
            end else begin
                if (ram_en) acc_cnt++;
                if (ram_en && ram_we) wr_cnt++;
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("rsp_err",   64'(rsp_err),   64'(mon_e.err));
                        check("rsp_read1", 64'(rsp_read1), 64'(mon_e.r1));
                        check("rsp_read2", 64'(rsp_read2), 64'(mon_e.r2));
                        check("sp",        64'(sp),        64'(mon_e.sp));
                        check("full",      64'(full),      64'(mon_e.sp == NENT));
                        check("empty",     64'(empty),     64'(mon_e.sp == 0));
                        check("latency",   64'(cyc + 1 - mon_e.acc_cyc), 64'(mon_e.lat));
                        check("ram_access", 64'(acc_cnt),  64'(mon_e.acc));
                        check("ram_writes", 64'(wr_cnt),   64'(mon_e.wr));
                        n_resp++;
                    end
                    acc_cnt = 0;
                    wr_cnt  = 0;
                end else if (sbq.size() != 0 && (cyc - sbq[0].acc_cyc) > 8) begin
                    check("rsp_timeout", 64'd1, 64'd0);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        logic acc;
        logic alt;
        int   sz;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_sp",        64'(sp),        64'd0);
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_full",      64'(full),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_ram_en",    64'(ram_en),    64'd0);
        check("rst_read1",     64'(rsp_read1), 64'd0);
        check("rst_ram_addr",  64'(ram_addr),  64'd0);
        reset = 1'b0;

        // Basic pushes and pops, then underflow cases.
        issue(PUSH, 32'h11); issue(PUSH, 32'h22); issue(PUSH, 32'h33);
        issue(POP2, '0); issue(POP1, '0);
        issue(PUSH, 32'h44); issue(POP2, '0); issue(POP1, '0); issue(POP1, '0);
        issue(NOP, '0);
        // Fill to capacity, overflow, pop the last word.
        for (int i = 0; i < 5; i++) issue(PUSH, 32'hA0 + 32'(i));
        issue(POP1, '0);
        drain();

        // Asynchronous reset while a pop2 is in READ_NEXT.
        issue(PUSH, $urandom); issue(PUSH, $urandom);
        drain();
        sz = stk.size();
        issue(POP2, '0);
        step(1'b0, NOP, '0, 1'b0, acc);
        step(1'b0, NOP, '0, 1'b0, acc);
        check("rn_ram_en",   64'(ram_en),   64'd1);
        check("rn_ram_addr", 64'(ram_addr), 64'((sz - 2) % NENT));
        #2 reset = 1'b1;
        #1;
        check("arst_ram_en",    64'(ram_en),    64'd0);
        check("arst_sp",        64'(sp),        64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        n_flushed += sbq.size();
        sbq.delete(); stk.delete();
        last_r1 = '0; last_r2 = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("arst_empty",     64'(empty),     64'd1);

        // cmd_valid held high, alternating push / pop1 per accept.
        alt = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1, alt ? POP1 : PUSH, $urandom, 1'b1, acc);
            if (acc) alt = ~alt;
        end
        drain();

        // Fully random traffic.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 1'b1, acc);
        drain();

        check("resp_count", 64'(n_resp), 64'(n_acc - n_flushed));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, total);
        $fatal(1, "timeout");
    end

endmodule
